// File: rtl/btn_step_ctrl.sv
// Front-panel conditioner: synchronises and debounces the push-buttons, then
// turns STEP / RUN-PAUSE presses into a single-cycle CPU clock-enable.
module btn_step_ctrl #(
    parameter int N_BTN      = 2,
    parameter int DEB_CYCLES = 16,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int DIV_W      = 24
) (
    input  logic             CLK1,
    input  logic             RST,
    input  logic [N_BTN-1:0] BTN,
    input  logic             MODE_RUN,
    input  logic [DIV_W-1:0] DIV,
    output logic [N_BTN-1:0] BTN_LEVEL,
    output logic [N_BTN-1:0] BTN_PRESS,
    output logic [N_BTN-1:0] BTN_RELEASE,
    output logic             CPU_EN,
    output logic             RUN_ACTIVE,
    output logic [15:0]      STEP_CNT
);

    localparam int               CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [N_BTN-1:0] RELEASED = {N_BTN{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        ST_STEP,
        ST_RUN,
        ST_PAUSE
    } state_t;

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] pressed;
    logic [N_BTN-1:0] flip;
    logic [CNT_W-1:0] deb_cnt [N_BTN];

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic             cpu_en_nxt;
    logic             step_now;

    always_ff @(posedge CLK1) begin
        if (RST) begin
            sync1 <= RELEASED;
            sync2 <= RELEASED;
        end else begin
            sync1 <= BTN;
            sync2 <= sync1;
        end
    end

    assign pressed = ACTIVE_LOW ? ~sync2 : sync2;

    // A channel flips on the DEB_CYCLES-th consecutive edge that disagrees
    always_comb begin
        flip = '0;
        for (int i = 0; i < N_BTN; i++) begin
            flip[i] = (pressed[i] != BTN_LEVEL[i]) && (deb_cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge CLK1) begin
        if (RST) begin
            BTN_LEVEL   <= '0;
            BTN_PRESS   <= '0;
            BTN_RELEASE <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            BTN_LEVEL   <= BTN_LEVEL ^ flip;
            BTN_PRESS   <= flip & pressed;
            BTN_RELEASE <= flip & ~pressed;
            for (int i = 0; i < N_BTN; i++) begin
                if ((pressed[i] != BTN_LEVEL[i]) && !flip[i]) begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Uses the unregistered press so CPU_EN lands in the same cycle as BTN_PRESS[0]
    assign step_now = flip[0] & pressed[0];

    always_comb begin
        state_nxt  = state;
        div_nxt    = div_cnt;
        cpu_en_nxt = 1'b0;
        case (state)
            ST_STEP: begin
                cpu_en_nxt = step_now;
                if (MODE_RUN) begin
                    state_nxt = ST_RUN;
                    div_nxt   = '0;
                end
            end
            ST_RUN: begin
                if (!MODE_RUN) begin
                    state_nxt = ST_STEP;
                    div_nxt   = '0;
                end else if (BTN_PRESS[1]) begin
                    state_nxt = ST_PAUSE;
                end else if (div_cnt >= DIV) begin
                    cpu_en_nxt = 1'b1;
                    div_nxt    = '0;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            ST_PAUSE: begin
                cpu_en_nxt = step_now;
                if (!MODE_RUN) begin
                    state_nxt = ST_STEP;
                    div_nxt   = '0;
                end else if (BTN_PRESS[1]) begin
                    state_nxt = ST_RUN;
                    div_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_STEP;
                div_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK1) begin
        if (RST) begin
            state      <= ST_STEP;
            div_cnt    <= '0;
            CPU_EN     <= 1'b0;
            RUN_ACTIVE <= 1'b0;
            STEP_CNT   <= '0;
        end else begin
            state      <= state_nxt;
            div_cnt    <= div_nxt;
            CPU_EN     <= cpu_en_nxt;
            RUN_ACTIVE <= (state_nxt == ST_RUN);
            if (CPU_EN) begin
                STEP_CNT <= STEP_CNT + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_btn_step_ctrl.sv
// Directed bench for btn_step_ctrl: cycle table for reset/debounce, then
// hand-timed sequences for run, pause/step, priority, reset and counter wrap.
module tb_btn_step_ctrl;

    localparam int N_BTN = 2;
    localparam int DEB   = 4;
    localparam int DIV_W = 24;

    logic             CLK1 = 1'b0;
    logic             RST;
    logic [N_BTN-1:0] BTN;
    logic             MODE_RUN;
    logic [DIV_W-1:0] DIV;
    logic [N_BTN-1:0] BTN_LEVEL;
    logic [N_BTN-1:0] BTN_PRESS;
    logic [N_BTN-1:0] BTN_RELEASE;
    logic             CPU_EN;
    logic             RUN_ACTIVE;
    logic [15:0]      STEP_CNT;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rst;
        logic [1:0]  btn;
        logic [1:0]  exp_level;
        logic [1:0]  exp_press;
        logic [1:0]  exp_release;
        logic        exp_cpu_en;
        logic [15:0] exp_step_cnt;
    } vec_t;

    vec_t vecs[$];

    btn_step_ctrl #(
        .N_BTN(N_BTN),
        .DEB_CYCLES(DEB),
        .ACTIVE_LOW(1'b1),
        .DIV_W(DIV_W)
    ) dut (
        .CLK1(CLK1),
        .RST(RST),
        .BTN(BTN),
        .MODE_RUN(MODE_RUN),
        .DIV(DIV),
        .BTN_LEVEL(BTN_LEVEL),
        .BTN_PRESS(BTN_PRESS),
        .BTN_RELEASE(BTN_RELEASE),
        .CPU_EN(CPU_EN),
        .RUN_ACTIVE(RUN_ACTIVE),
        .STEP_CNT(STEP_CNT)
    );

    always #5 CLK1 = ~CLK1;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [1:0] b, input logic m,
                                 input logic [DIV_W-1:0] d);
        RST      = r;
        BTN      = b;
        MODE_RUN = m;
        DIV      = d;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK1);
        #1;
    endtask

    task automatic addVecs(input int n, input logic r, input logic [1:0] b,
                           input logic [1:0] lvl, input logic [1:0] prs,
                           input logic [1:0] rel, input logic en, input logic [15:0] cnt);
        vec_t v;
        v.rst          = r;
        v.btn          = b;
        v.exp_level    = lvl;
        v.exp_press    = prs;
        v.exp_release  = rel;
        v.exp_cpu_en   = en;
        v.exp_step_cnt = cnt;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    initial begin
        // Raw buttons are active-low: 2'b11 means nothing pressed
        addVecs(3, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 16'd0);
        addVecs(2, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 16'd0);
        addVecs(5, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 16'd0);
        addVecs(1, 1'b0, 2'b10, 2'b01, 2'b01, 2'b00, 1'b1, 16'd0);
        addVecs(1, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 16'd1);
        addVecs(3, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 16'd1);
        addVecs(4, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 16'd1);
        addVecs(5, 1'b0, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0, 16'd1);
        addVecs(1, 1'b0, 2'b11, 2'b00, 2'b00, 2'b01, 1'b0, 16'd1);
        addVecs(1, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 16'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].btn, 1'b0, 24'd3);
            tick(1);
            checkOutput($sformatf("v%0d.level", i), BTN_LEVEL, vecs[i].exp_level);
            checkOutput($sformatf("v%0d.press", i), BTN_PRESS, vecs[i].exp_press);
            checkOutput($sformatf("v%0d.release", i), BTN_RELEASE, vecs[i].exp_release);
            checkOutput($sformatf("v%0d.cpu_en", i), CPU_EN, vecs[i].exp_cpu_en);
            checkOutput($sformatf("v%0d.run_active", i), RUN_ACTIVE, 1'b0);
            checkOutput($sformatf("v%0d.step_cnt", i), STEP_CNT, vecs[i].exp_step_cnt);
        end

        // Run with DIV=3: entry edge, then a pulse every fourth edge
        applyStimulus(1'b0, 2'b11, 1'b1, 24'd3);
        tick(1);
        checkOutput("run.active", RUN_ACTIVE, 1'b1);
        checkOutput("run.en0", CPU_EN, 1'b0);
        for (int i = 1; i <= 41; i++) begin
            tick(1);
            checkOutput($sformatf("run.en%0d", i), CPU_EN, (i % 4 == 0));
        end
        checkOutput("run.step_cnt", STEP_CNT, 16'd11);

        applyStimulus(1'b0, 2'b11, 1'b1, 24'd0);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            checkOutput($sformatf("div0.en%0d", i), CPU_EN, 1'b1);
        end
        checkOutput("div0.step_cnt", STEP_CNT, 16'd18);

        // Pause via BTN[1] while running with DIV=3
        applyStimulus(1'b0, 2'b01, 1'b1, 24'd3);
        tick(6);
        checkOutput("pause.press1", BTN_PRESS, 2'b10);
        checkOutput("pause.en_pre", CPU_EN, 1'b0);
        tick(1);
        checkOutput("pause.active", RUN_ACTIVE, 1'b0);
        checkOutput("pause.en", CPU_EN, 1'b0);
        checkOutput("pause.step_cnt", STEP_CNT, 16'd20);
        applyStimulus(1'b0, 2'b11, 1'b1, 24'd3);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            checkOutput($sformatf("pause.idle%0d", i), CPU_EN, 1'b0);
        end

        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 2'b10, 1'b1, 24'd3);
            for (int j = 1; j <= 6; j++) begin
                tick(1);
                checkOutput($sformatf("pstep%0d.en%0d", k, j), CPU_EN, (j == 6));
            end
            checkOutput($sformatf("pstep%0d.press0", k), BTN_PRESS, 2'b01);
            applyStimulus(1'b0, 2'b11, 1'b1, 24'd3);
            for (int j = 0; j < 8; j++) begin
                tick(1);
                checkOutput($sformatf("pstep%0d.rel%0d", k, j), CPU_EN, 1'b0);
            end
        end
        checkOutput("pstep.step_cnt", STEP_CNT, 16'd22);
        checkOutput("pstep.active", RUN_ACTIVE, 1'b0);

        // Resume: divider restarts from 0 so the first pulse is four edges later
        applyStimulus(1'b0, 2'b01, 1'b1, 24'd3);
        tick(6);
        checkOutput("resume.press1", BTN_PRESS, 2'b10);
        tick(1);
        checkOutput("resume.active", RUN_ACTIVE, 1'b1);
        checkOutput("resume.en0", CPU_EN, 1'b0);
        for (int j = 1; j <= 4; j++) begin
            tick(1);
            checkOutput($sformatf("resume.en%0d", j), CPU_EN, (j == 4));
        end

        // MODE_RUN drop wins over a simultaneous BTN_PRESS[1]
        applyStimulus(1'b0, 2'b11, 1'b1, 24'd3);
        tick(8);
        applyStimulus(1'b0, 2'b01, 1'b1, 24'd3);
        tick(6);
        checkOutput("prio.press1", BTN_PRESS, 2'b10);
        applyStimulus(1'b0, 2'b11, 1'b0, 24'd3);
        tick(1);
        checkOutput("prio.left_run", RUN_ACTIVE, 1'b0);
        applyStimulus(1'b0, 2'b11, 1'b1, 24'd3);
        tick(1);
        checkOutput("prio.was_step", RUN_ACTIVE, 1'b1);
        tick(8);
        checkOutput("prio.level", BTN_LEVEL, 2'b00);

        // Reset in the middle of running
        applyStimulus(1'b1, 2'b11, 1'b1, 24'd0);
        tick(1);
        checkOutput("rst.step_cnt", STEP_CNT, 16'd0);
        checkOutput("rst.active", RUN_ACTIVE, 1'b0);
        checkOutput("rst.en", CPU_EN, 1'b0);
        applyStimulus(1'b0, 2'b11, 1'b1, 24'd0);
        tick(1);
        checkOutput("rst.reenter", RUN_ACTIVE, 1'b1);
        checkOutput("rst.en_entry", CPU_EN, 1'b0);

        // DIV=0 pulses every edge; 65536 pulses bring STEP_CNT to FFFF, then wrap
        tick(1);
        checkOutput("wrap.first_en", CPU_EN, 1'b1);
        checkOutput("wrap.first_cnt", STEP_CNT, 16'd0);
        tick(65535);
        checkOutput("wrap.ffff", STEP_CNT, 16'hFFFF);
        checkOutput("wrap.en", CPU_EN, 1'b1);
        tick(1);
        checkOutput("wrap.zero", STEP_CNT, 16'h0000);
        tick(1);
        checkOutput("wrap.one", STEP_CNT, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_step_ctrl.md
Name: btn_step_ctrl

Overview:
Parametrised front-panel conditioner for the 4-bit CPU board top level. It synchronises and debounces N raw push-buttons and produces level, press and release signals. It also generates the CPU clock-enable (CPU_EN) in three modes: single-step, free-run with programmable divider, and paused-with-step. It replaces direct use of a raw BTN[0] as the CPU step clock.

Parameters:
N_BTN, 2, number of button channels; must be >= 2 (channel 0 = STEP, channel 1 = RUN/PAUSE toggle)
DEB_CYCLES, 16, consecutive stable cycles required to accept a new level; >= 1
ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed; 0 = reads 1 when pressed
DIV_W, 24, width of run-mode divider

Ports:
CLK1  in  1  system clock; all logic on rising edge
RST  in  1  synchronous, active-high reset
BTN  in  N_BTN  raw asynchronous button inputs
MODE_RUN  in  1  level: 1 = run/pause modes, 0 = step mode
DIV  in  DIV_W  run-mode period minus 1; CPU_EN fires every DIV+1 cycles
BTN_LEVEL  out  N_BTN  debounced pressed level (1 = pressed)
BTN_PRESS  out  N_BTN  one-cycle pulse on debounced press
BTN_RELEASE  out  N_BTN  one-cycle pulse on debounced release
CPU_EN  out  1  one-cycle CPU clock-enable pulse
RUN_ACTIVE  out  1  1 while in RUN state
STEP_CNT  out  16  count of CPU_EN pulses issued

Behaviour:
- Reset (RST high at an edge): sync flops load the released value; debounce counters are 0; BTN_LEVEL, BTN_PRESS, BTN_RELEASE, CPU_EN, RUN_ACTIVE and STEP_CNT are 0; divider is 0; FSM goes to STEP. Reset mid-debounce or mid-run discards all progress.
- Per channel: 2-flop synchroniser, then polarity normalise (pressed = 1).
- Debounce:
  - Counter increments at each edge where the synchronised value differs from BTN_LEVEL.
  - Counter clears at any edge where they match.
  - At the DEB_CYCLES-th consecutive differing edge, BTN_LEVEL flips and the counter clears.
  - Total latency from a stable raw change to the BTN_LEVEL change is DEB_CYCLES+2 edges.
  - A glitch shorter than DEB_CYCLES cycles never changes BTN_LEVEL.
- BTN_PRESS[i] / BTN_RELEASE[i] are registered at the same edge that BTN_LEVEL[i] rises / falls. They are high for exactly the first cycle of the new level.
- FSM states: STEP, RUN, PAUSE.
  - STEP: CPU_EN = 1 for the cycle in which BTN_PRESS[0] = 1. Goes to RUN when MODE_RUN = 1; the divider clears on entry.
  - RUN: divider counts up each cycle. When divider >= DIV, CPU_EN pulses and the divider wraps to 0. DIV = 0 gives CPU_EN every cycle. Lowering DIV below the current count gives a pulse on the next edge, then a wrap. BTN_PRESS[1] goes to PAUSE. BTN_PRESS[0] is ignored.
  - PAUSE: divider holds. BTN_PRESS[0] issues one CPU_EN pulse. BTN_PRESS[1] returns to RUN; the divider clears.
  - From any state, MODE_RUN = 0 goes to STEP and clears the divider. MODE_RUN has priority over a simultaneous BTN_PRESS[1].
- CPU_EN timing: CPU_EN is registered. In STEP/PAUSE it coincides with the BTN_PRESS[0] cycle. In RUN it is asserted the cycle after the divider reaches DIV. CPU_EN is never high two cycles in a row, except in RUN with DIV = 0.
- RUN_ACTIVE = 1 exactly while the state is RUN (registered with the state).
- STEP_CNT increments by 1 on every edge where CPU_EN is high. It wraps 16'hFFFF -> 0.
- Channels >= 2 are debounced only; they do not affect the FSM.

Test Plan:
- Reset/polarity (DEB_CYCLES=4, ACTIVE_LOW=1): hold RST 3 cycles with BTN=2'b11 -> all outputs 0 and state STEP. Release RST -> outputs stay 0.
- Debounce latency: drive BTN[0] 1->0 and hold -> BTN_LEVEL[0] rises at edge 6 after the change; BTN_PRESS[0] and CPU_EN high for exactly 1 cycle; STEP_CNT = 1. Then a 3-cycle low glitch on BTN[1] -> no change on BTN_LEVEL[1].
- Release: raise BTN[0] back to 1 and hold -> BTN_RELEASE[0] is a 1-cycle pulse 6 edges later; no CPU_EN.
- Run divider: MODE_RUN=1, DIV=3 -> RUN_ACTIVE=1 and CPU_EN every 4 cycles. After 40 cycles STEP_CNT = 11 (1 carried from the step test). Set DIV=0 -> CPU_EN held high continuously.
- Pause/step: in RUN press BTN[1] -> PAUSE, RUN_ACTIVE=0, CPU_EN stops. Press BTN[0] twice -> exactly 2 pulses. Press BTN[1] -> RUN resumes with the divider cleared.
- Priority/wrap: drop MODE_RUN in the same cycle as BTN_PRESS[1] -> state STEP. Preload STEP_CNT near 16'hFFFF via 65535 DIV=0 cycles, then one more CPU_EN -> STEP_CNT = 0. Assert RST mid-RUN -> STEP state and STEP_CNT = 0 next cycle.
